booth_mult_scheduler: RTL and testbench
=======================================

// Module: booth_mult_scheduler
// PURPOSE
//  Shares one radix-2 Booth multiplier (start/ready handshake, signed WxW -> 2W product) between N requesters.
//  Round-robin arbitration; latches the winner's operands and pulses mul_start.
//  Waits for mul_ready, then returns the product with the requester ID on one back-pressured response channel.
//  Sits between the client blocks and the multiplier instance; the multiplier itself is external.
// PARAMETERS
//  N        4    number of requesters (2..8)
//  W        4    operand width; product is 2W, two's complement
//  TIMEOUT  32   max cycles in WAIT before aborting with rsp_err
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  reset      in   1      asynchronous, active-low reset (0 = reset asserted)
//  req_valid  in   N      per-requester request pending
//  req_a      in   N*W    packed operand A, requester i at [i*W +: W]
//  req_b      in   N*W    packed operand B, same packing
//  req_ready  out  N      one-hot accept; request i taken when req_valid[i] & req_ready[i]
//  rsp_valid  out  1      response valid
//  rsp_id     out  $clog2(N)  requester index of response
//  rsp_p      out  2W     signed product (0 on error)
//  rsp_err    out  1      1 = multiplier timed out
//  rsp_ready  in   1      response consumer accept
//  mul_start  out  1      one-cycle start pulse to multiplier
//  mul_a      out  W      operand A to multiplier, stable from ISSUE until return to IDLE
//  mul_b      out  W      operand B, same
//  mul_p      in   2W     multiplier product
//  mul_ready  in   1      multiplier done/idle
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0,
//   mul_start=0, mul_a=0, mul_b=0, rr pointer=N-1 (requester 0 wins first), timeout count=0.
//  FSM: IDLE -> ISSUE -> GUARD -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid, req_ready is driven combinationally one-hot to the first valid index from ptr+1 upward (mod N).
//   The accepted a/b are registered into mul_a/mul_b; id is latched; ptr := winner; next state ISSUE. No valid: stay in IDLE.
//  ISSUE: mul_start=1 for exactly this cycle; -> GUARD.
//  GUARD: one cycle; mul_ready ignored (covers the multiplier's ready-drop latency); -> WAIT; clear timeout count.
//  WAIT: if mul_ready=1: capture rsp_p=mul_p, rsp_err=0, -> RESP.
//   Else count++; when count reaches TIMEOUT-1 with mul_ready still 0: rsp_p=0, rsp_err=1, -> RESP.
//  RESP: rsp_valid=1, rsp_id/rsp_p/rsp_err held stable. On rsp_ready=1 -> IDLE.
//   Back-to-back: the grant happens in the next IDLE cycle, not in the same cycle as the handshake.
//  Latency: accept at cycle 0; mul_start at 1; rsp_valid asserts the cycle after mul_ready is first seen in WAIT.
//  req_ready is 0 in every state except IDLE; a request must hold req_valid and operands until accepted.
//  Requests withdrawn before acceptance are never serviced; no queuing inside the block.
//  Arithmetic: product passed through unmodified, 2W bits signed; no saturation.
//  Fairness: with all N requesting continuously, the grant order is 0,1,..,N-1,0,...
//   A requester waits at most N-1 operations.
//  Reset mid-operation: FSM to IDLE and outputs to reset values at once; the in-flight result is dropped.
//   mul_start must not glitch high during or on release of reset.
// TESTING
//  1 Req0 a=4'h5 b=4'h6, mul_ready after 6 cycles -> one mul_start pulse, rsp_valid with id=0, p=8'h1E, err=0.
//  2 Req2 a=4'hD(-3) b=4'h7 -> rsp_p=8'hEB (-21), id=2; mul_a/mul_b stable from ISSUE to RESP exit.
//  3 All 4 requesting from reset, rsp_ready=1 -> responses in id order 0,1,2,3,0; exactly one req_ready per grant.
//  4 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_p/rsp_id stable, req_ready stays 0, no new mul_start.
//  5 mul_ready stuck 0 -> rsp_valid TIMEOUT cycles after GUARD, rsp_err=1, rsp_p=0; next request serviced normally.
//  6 reset=0 asserted in WAIT -> all outputs to reset values same cycle; after release, req1 alone is granted
//    (ptr reset -> 0 priority, 1 next).

Source files
------------

// File: rtl/booth_mult_scheduler_if.sv
// Bundle of request, response and multiplier signals for the shared Booth multiplier scheduler.
// The slave side is the scheduler; the master side is the client/multiplier environment.
interface booth_mult_scheduler_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_p;
    logic             rsp_err;
    logic             mul_start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;
    logic             mul_ready;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_p, mul_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_p, mul_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one external start/ready Booth multiplier among N requesters,
// returning each product (or a timeout error) tagged with the requester id.
module booth_mult_scheduler #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    booth_mult_scheduler_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      id_q;
    logic [CW-1:0]       cnt_q;
    logic [W-1:0]        mul_a_q;
    logic [W-1:0]        mul_b_q;
    logic                mul_start_q;
    logic                rsp_valid_q;
    logic [2*W-1:0]      rsp_p_q;
    logic                rsp_err_q;

    logic [N-1:0][W-1:0] a_arr;
    logic [N-1:0][W-1:0] b_arr;
    logic [N-1:0]        gnt_d;
    logic [IDW-1:0]      win_d;
    logic [IDW-1:0]      idx_d;
    logic                found_d;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*W +: W];
        assign b_arr[i] = bus.req_b[i*W +: W];
    end

    // Scan from the requester after the last winner; only ever grants while idle.
    always_comb begin
        gnt_d   = '0;
        win_d   = '0;
        idx_d   = '0;
        found_d = 1'b0;
        if (state_q == S_IDLE) begin
            for (int k = 1; k <= N; k++) begin
                idx_d = IDW'((int'(ptr_q) + k) % N);
                if (!found_d && bus.req_valid[idx_d]) begin
                    found_d = 1'b1;
                    win_d   = idx_d;
                end
            end
            if (found_d) gnt_d[win_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(N - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (found_d) begin
                    mul_a_q     <= a_arr[win_d];
                    mul_b_q     <= b_arr[win_d];
                    id_q        <= win_d;
                    ptr_q       <= win_d;
                    mul_start_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_GUARD;
                // Multiplier may still show ready from the previous job here.
                S_GUARD: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mul_ready) begin
                        rsp_p_q     <= bus.mul_p;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                        rsp_p_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = gnt_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Scoreboard bench: clients push expected responses on acceptance, a monitor pops and compares
// on every response handshake; a simple start/ready multiplier model stands in for the Booth unit.
module tb_booth_mult_scheduler;
    localparam int N = 4, W = 4, TIMEOUT = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    booth_mult_scheduler_if #(.N(N), .W(W)) bus ();
    booth_mult_scheduler #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {int id; logic [7:0] p; logic err; int lat; logic [W-1:0] a; logic [W-1:0] b;} exp_t;
    typedef struct {int id; logic [W-1:0] a; logic [W-1:0] b;} post_t;

    exp_t  exp_q[$];
    post_t post_q[$];
    int    ids_log[$];
    logic [7:0] p_log[$];

    int n_tests = 0, n_fail = 0;
    int mdly = 4;
    bit stuck = 0, refill = 0, hold_rsp = 0, rand_bp = 0;
    int n_grant = 0, n_done = 0, starts = 0, cyc = 0;

    function automatic logic [7:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [7:0] x, y;
        x = {{W{a[W-1]}}, a};
        y = {{W{b[W-1]}}, b};
        return 8'(x * y);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // External multiplier: ready drops after start, result appears mdly cycles later (never if stuck).
    logic       mrdy;
    logic [7:0] mp;
    int         mcnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mrdy <= 1'b1; mcnt <= 0; mp <= '0;
        end else if (bus.mul_start) begin
            mrdy <= 1'b0; mcnt <= mdly;
        end else if (!mrdy && !stuck) begin
            if (mcnt <= 1) begin
                mrdy <= 1'b1;
                mp   <= smul(bus.mul_a, bus.mul_b);
            end else mcnt <= mcnt - 1;
        end
    end
    assign bus.mul_ready = mrdy;
    assign bus.mul_p     = mp;

    // Clients: hold requests until accepted, record expectation on acceptance.
    initial begin
        logic [N-1:0] g;
        int acc;
        post_t keep[$];
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        forever begin
            @(negedge clk);
            acc = -1;
            if (!reset) n_grant = 0;
            else begin
                g = bus.req_valid & bus.req_ready;
                for (int i = N - 1; i >= 0; i--) if (g[i]) acc = i;
            end
            @(posedge clk); #1;
            if (acc >= 0 && reset) begin
                exp_t e;
                e.id  = acc;
                e.a   = bus.req_a[acc*W +: W];
                e.b   = bus.req_b[acc*W +: W];
                e.err = stuck;
                e.p   = stuck ? 8'h00 : smul(e.a, e.b);
                e.lat = stuck ? TIMEOUT + 1 : mdly + 2;
                exp_q.push_back(e);
                n_grant++;
                if (refill) begin
                    bus.req_a[acc*W +: W] = W'($urandom);
                    bus.req_b[acc*W +: W] = W'($urandom);
                end else bus.req_valid[acc] = 1'b0;
            end
            keep.delete();
            foreach (post_q[k]) begin
                if (!bus.req_valid[post_q[k].id]) begin
                    bus.req_valid[post_q[k].id]          = 1'b1;
                    bus.req_a[post_q[k].id*W +: W] = post_q[k].a;
                    bus.req_b[post_q[k].id*W +: W] = post_q[k].b;
                end else keep.push_back(post_q[k]);
            end
            post_q = keep;
        end
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = hold_rsp ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: arbitration reference, start/operand checks, response scoreboard.
    initial begin
        int mptr, w, j, start_cyc;
        bit prev_hold, prev_start;
        logic [1:0] prev_id;
        logic [7:0] prev_p;
        logic prev_err;
        logic [N-1:0] exp_g;
        exp_t e;
        mptr = N - 1; start_cyc = 0; prev_hold = 0; prev_start = 0;
        prev_id = '0; prev_p = '0; prev_err = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                exp_q.delete(); n_done = 0; starts = 0; mptr = N - 1;
                prev_hold = 0; prev_start = 0;
                continue;
            end
            if (bus.req_ready != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (mptr + k) % N;
                    if (w < 0 && bus.req_valid[j]) w = j;
                end
                exp_g = '0;
                if (w >= 0) begin exp_g[w] = 1'b1; mptr = w; end
                chk("grant", bus.req_ready, exp_g);
            end
            if (bus.mul_start) begin
                chk("start_single", prev_start, 0);
                chk("start_after_grant", n_grant, starts + 1);
                starts++;
                start_cyc = cyc;
            end
            if (starts == n_done + 1 && exp_q.size() > 0) begin
                chk("mul_a", bus.mul_a, exp_q[0].a);
                chk("mul_b", bus.mul_b, exp_q[0].b);
            end
            if (bus.rsp_valid) begin
                chk("rdy_in_resp", bus.req_ready, 0);
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    if (!prev_hold) chk("latency", cyc - start_cyc, exp_q[0].lat);
                    else begin
                        chk("hold_id", bus.rsp_id, prev_id);
                        chk("hold_p", bus.rsp_p, prev_p);
                        chk("hold_err", bus.rsp_err, prev_err);
                    end
                    if (bus.rsp_ready) begin
                        e = exp_q.pop_front();
                        chk("rsp_id", bus.rsp_id, e.id);
                        chk("rsp_p", bus.rsp_p, e.p);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("one_start_per_rsp", starts, n_done + 1);
                        n_done++;
                        ids_log.push_back(int'(bus.rsp_id));
                        p_log.push_back(bus.rsp_p);
                    end
                end
            end
            prev_hold  = bus.rsp_valid && !bus.rsp_ready;
            prev_id    = bus.rsp_id; prev_p = bus.rsp_p; prev_err = bus.rsp_err;
            prev_start = bus.mul_start;
        end
    end

    task automatic post(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        post_t p;
        p.id = id; p.a = a; p.b = b;
        post_q.push_back(p);
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        do begin
            @(posedge clk); #3; c++;
        end while ((exp_q.size() != 0 || post_q.size() != 0 || bus.req_valid != '0 || bus.rsp_valid) && c < maxc);
        if (c >= maxc) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", maxc);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_id"},    bus.rsp_id, 0);
        chk({tag, "_rsp_p"},     bus.rsp_p, 0);
        chk({tag, "_rsp_err"},   bus.rsp_err, 0);
        chk({tag, "_mul_start"}, bus.mul_start, 0);
        chk({tag, "_mul_a"},     bus.mul_a, 0);
        chk({tag, "_mul_b"},     bus.mul_b, 0);
    endtask

    initial begin
        int base, c, s0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outs("rst");
        @(posedge clk); #2 reset = 1'b1;

        // 5*6 with a 6-cycle multiplier
        mdly = 6;
        post(0, 4'h5, 4'h6);
        wait_idle(200);
        chk("t1_p", p_log.size() > 0 ? p_log[p_log.size()-1] : 8'hxx, 8'h1E);
        // -3*7 from requester 2
        post(2, 4'hD, 4'h7);
        wait_idle(200);
        chk("t2_p", p_log.size() > 0 ? p_log[p_log.size()-1] : 8'hxx, 8'hEB);
        chk("t2_id", ids_log.size() > 0 ? ids_log[ids_log.size()-1] : -1, 2);

        // All four requesting continuously from reset
        @(posedge clk); #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        mdly = 2; refill = 1;
        base = ids_log.size();
        for (int i = 0; i < N; i++) post(i, W'($urandom), W'($urandom));
        c = 0;
        while (ids_log.size() < base + 5 && c < 300) begin @(posedge clk); #3; c++; end
        refill = 0;
        wait_idle(300);
        for (int k = 0; k < 5; k++)
            chk("t3_order", ids_log.size() > base + k ? ids_log[base+k] : -1, k % N);

        // Response back-pressure with another request waiting
        hold_rsp = 1;
        post(1, 4'h7, 4'h7);
        c = 0;
        while (!bus.rsp_valid && c < 100) begin @(posedge clk); #3; c++; end
        post(3, 4'h2, 4'h3);
        s0 = starts;
        repeat (10) @(posedge clk);
        #3;
        chk("t4_valid_held", bus.rsp_valid, 1);
        chk("t4_no_start", starts, s0);
        hold_rsp = 0;
        wait_idle(200);

        // Stuck multiplier times out, next one is normal
        stuck = 1;
        post(0, 4'h3, 4'h3);
        wait_idle(200);
        stuck = 0;
        post(1, 4'h2, 4'hF);
        wait_idle(200);
        chk("t5_next_p", p_log.size() > 0 ? p_log[p_log.size()-1] : 8'hxx, 8'hFE);

        // Reset while waiting on a slow multiplier
        mdly = 20;
        post(2, 4'h4, 4'h4);
        c = 0; s0 = starts;
        while (starts == s0 && c < 100) begin @(posedge clk); #3; c++; end
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outs("t6");
        mdly = 3;
        post(1, 4'h6, 4'h2);
        post(3, 4'h1, 4'h1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        base = ids_log.size();
        wait_idle(200);
        chk("t6_first", ids_log.size() > base ? ids_log[base] : -1, 1);
        chk("t6_second", ids_log.size() > base + 1 ? ids_log[base+1] : -1, 3);

        // Randomised batches with random back-pressure
        rand_bp = 1;
        for (int it = 0; it < 20; it++) begin
            mdly  = $urandom_range(1, 5);
            stuck = (it % 7 == 3);
            for (int r = 0; r < int'($urandom_range(1, 4)); r++)
                post($urandom_range(0, N - 1), W'($urandom), W'($urandom));
            wait_idle(800);
        end
        stuck = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
